// File: rtl/lod_pkg.sv
// lod_pipe shared definitions: lane-mode constants, mode type,
// and the elaboration-time geometry check.
package lod_pkg;

    localparam int LOD_MODE_FULL    = 0;
    localparam int LOD_MODE_HALF    = 1;
    localparam int LOD_MODE_QUARTER = 2;

    // Wide enough for any practical log2(LANES)
    typedef logic [3:0] lod_mode_t;

    function automatic bit lod_cfg_ok(
        input int width,
        input int lanes,
        input int seg
    );
        return width == lanes * seg;
    endfunction

endpackage

// File: rtl/lod_pipe_if.sv
// Valid/ready bundle for lod_pipe: operand beat in, per-lane
// leading-zero counts and zero flags out.
interface lod_pipe_if #(
    parameter int WIDTH  = 112,
    parameter int LANES  = 4,
    parameter int POS_W  = 7,
    parameter int MODE_W = 2
);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [MODE_W-1:0]      in_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*POS_W-1:0] out_lzc;
    logic [LANES-1:0]       out_zero;
    logic [MODE_W-1:0]      out_mode;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_lzc, out_zero, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_lzc, out_zero, out_mode
    );

endinterface

// File: rtl/lod_seg.sv
// Combinational leading-zero count of one SEG-bit segment,
// with an all-zero flag (count saturates at SEG).
module lod_seg #(
    parameter int SEG = 28,
    parameter int CW  = $clog2(SEG + 1)
) (
    input  logic [SEG-1:0] d,
    output logic [CW-1:0]  cnt,
    output logic           zero
);

    // Scan upward so the highest set bit wins
    always_comb begin
        cnt = CW'(SEG);
        for (int i = 0; i < SEG; i++) begin
            if (d[i]) cnt = CW'(SEG - 1 - i);
        end
    end

    assign zero = ~|d;

endmodule

// File: rtl/lod_pipe.sv
// Pipelined multi-precision leading-zero counter.
// Define LOD_PIPE_OUTREG_EN to add a third output register stage.
module lod_pipe
    import lod_pkg::*;
#(
    parameter int WIDTH  = 112,
    parameter int LANES  = 4,
    parameter int SEG    = WIDTH / LANES,
    parameter int POS_W  = $clog2(WIDTH + 1),
    parameter int MODE_W = ($clog2($clog2(LANES) + 1) < 1) ? 1
                         : $clog2($clog2(LANES) + 1)
) (
    input logic       clk,
    input logic       rst,
    lod_pipe_if.slave bus
);

    localparam int CW    = $clog2(SEG + 1);
    localparam int LOG_L = $clog2(LANES);
    localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1;

    if (!lod_cfg_ok(WIDTH, LANES, SEG)) begin : g_cfg_err
        $error("lod_pipe: WIDTH must equal LANES*SEG");
    end

    logic [LANES-1:0][CW-1:0] seg_cnt;
    logic [LANES-1:0]         seg_zero;

    for (genvar s = 0; s < LANES; s++) begin : g_seg
        lod_seg #(.SEG(SEG)) u_seg (
            .d    (bus.in_data[s*SEG +: SEG]),
            .cnt  (seg_cnt[s]),
            .zero (seg_zero[s])
        );
    end

    lod_mode_t         req_mode;
    logic [MODE_W-1:0] eff_mode;

    // Reserved modes collapse to a single full-width lane
    always_comb begin
        req_mode = lod_mode_t'(bus.in_mode);
        if (req_mode > lod_mode_t'(LOG_L))
            req_mode = lod_mode_t'(LOD_MODE_FULL);
        eff_mode = MODE_W'(req_mode);
    end

    logic                     alive;
    logic                     s1_valid;
    logic [LANES-1:0][CW-1:0] s1_cnt;
    logic [LANES-1:0]         s1_zero;
    logic [MODE_W-1:0]        s1_mode;

    logic                     s2_valid;
    logic [LANES*POS_W-1:0]   s2_lzc;
    logic [LANES-1:0]         s2_zero;
    logic [MODE_W-1:0]        s2_mode;

    logic s1_load;
    logic s2_load;
    logic in_rdy;
    logic accept;

    logic [LANES*POS_W-1:0] cmb_lzc;
    logic [LANES-1:0]       cmb_zero;

    // Walk each lane's segments from its top segment down
    always_comb begin
        cmb_lzc  = '0;
        cmb_zero = '0;
        for (int g = 0; g < LANES; g++) begin
            int               k;
            logic             done;
            logic [POS_W-1:0] acc;
            logic [IW-1:0]    idx;
            k    = LANES >> s1_mode;
            done = 1'b0;
            acc  = '0;
            idx  = '0;
            if (g * k < LANES) begin
                for (int j = LANES - 1; j >= 0; j--) begin
                    if (j < k && !done) begin
                        idx = IW'(g * k + j);
                        if (s1_zero[idx]) begin
                            acc = acc + POS_W'(SEG);
                        end else begin
                            acc  = acc + POS_W'(s1_cnt[idx]);
                            done = 1'b1;
                        end
                    end
                end
                cmb_lzc[g*POS_W +: POS_W] = acc;
                cmb_zero[g]               = !done;
            end
        end
    end

`ifdef LOD_PIPE_OUTREG_EN
    logic                   s3_valid;
    logic [LANES*POS_W-1:0] s3_lzc;
    logic [LANES-1:0]       s3_zero;
    logic [MODE_W-1:0]      s3_mode;
    logic                   s3_load;

    assign s3_load = !s3_valid || bus.out_ready;
    assign s2_load = !s2_valid || s3_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_lzc   <= '0;
            s3_zero  <= '0;
            s3_mode  <= '0;
        end else if (s3_load) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_lzc  <= s2_lzc;
                s3_zero <= s2_zero;
                s3_mode <= s2_mode;
            end
        end
    end

    assign bus.out_valid = s3_valid;
    assign bus.out_lzc   = s3_lzc;
    assign bus.out_zero  = s3_zero;
    assign bus.out_mode  = s3_mode;
`else
    assign s2_load = !s2_valid || bus.out_ready;

    assign bus.out_valid = s2_valid;
    assign bus.out_lzc   = s2_lzc;
    assign bus.out_zero  = s2_zero;
    assign bus.out_mode  = s2_mode;
`endif

    assign s1_load      = !s1_valid || s2_load;
    assign in_rdy       = alive && s1_load;
    assign accept       = bus.in_valid && in_rdy;
    assign bus.in_ready = in_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive    <= 1'b0;
            s1_valid <= 1'b0;
            s1_cnt   <= '0;
            s1_zero  <= '0;
            s1_mode  <= '0;
            s2_valid <= 1'b0;
            s2_lzc   <= '0;
            s2_zero  <= '0;
            s2_mode  <= '0;
        end else begin
            alive <= 1'b1;
            if (s1_load) s1_valid <= accept;
            if (accept) begin
                s1_cnt  <= seg_cnt;
                s1_zero <= seg_zero;
                s1_mode <= eff_mode;
            end
            if (s2_load) s2_valid <= s1_valid;
            if (s2_load && s1_valid) begin
                s2_lzc  <= cmb_lzc;
                s2_zero <= cmb_zero;
                s2_mode <= s1_mode;
            end
        end
    end

endmodule

// File: tb/tb_lod_pipe.sv
// Randomised and directed bench for lod_pipe against a
// per-lane bit-scan reference model.
module tb_lod_pipe;

    localparam int W  = 112;
    localparam int L  = 4;
    localparam int PW = 7;
    localparam int MW = 2;
`ifdef LOD_PIPE_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [L*PW-1:0] lzc;
        logic [L-1:0]    z;
        logic [MW-1:0]   m;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lod_pipe_if bus ();

    lod_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t q[$];
    int    total = 0;
    int    bad   = 0;
    bit    rnd   = 1'b0;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Each lane is a W/G-bit slice scanned from its own MSB
    function automatic beat_t ref_lod(input logic [W-1:0] d,
                                      input logic [MW-1:0] m);
        beat_t r;
        int    em;
        int    gn;
        int    w;
        int    cnt;
        r  = '0;
        em = (int'(m) > $clog2(L)) ? 0 : int'(m);
        gn = 1 << em;
        w  = W / gn;
        r.m = MW'(em);
        for (int g = 0; g < gn; g++) begin
            cnt = w;
            for (int b = w - 1; b >= 0; b--) begin
                if (d[g*w + b]) begin
                    cnt = w - 1 - b;
                    break;
                end
            end
            r.lzc[g*PW +: PW] = PW'(cnt);
            r.z[g]            = (cnt == w);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        beat_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                check("lzc",  bus.out_lzc,  e.lzc);
                check("zero", bus.out_zero, e.z);
                check("mode", bus.out_mode, e.m);
            end
        end
    end

    task automatic rand_ready();
        if (rnd) bus.out_ready = ($urandom_range(3) != 0);
    endtask

    task automatic send_exp(input logic [W-1:0] d,
                            input logic [MW-1:0] m,
                            input beat_t ex);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back(ex);
                break;
            end
            n++;
            if (n > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
            rand_ready();
        end
        @(posedge clk);
        #1;
        rand_ready();
    endtask

    task automatic send(input logic [W-1:0] d,
                        input logic [MW-1:0] m);
        send_exp(d, m, ref_lod(d, m));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [127:0] r;
        logic [W-1:0] d;
        r = {$urandom, $urandom, $urandom, $urandom};
        d = r[W-1:0];
        for (int c = 0; c < 8; c++)
            if ($urandom_range(2) == 0) d[c*14 +: 14] = '0;
        d = d >> $urandom_range(40);
        return d;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]    d;
        beat_t           ex;
        logic [L*PW-1:0] held_lzc;
        logic [L-1:0]    held_z;
        int              n;
        int              stale;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_out_lzc",   bus.out_lzc,   0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("ready_after_rst", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Full mode, single one at bit 100, with latency check
        d = '0;
        d[100] = 1'b1;
        ex = '{lzc: 28'd11, z: 4'b0000, m: 2'd0};
        send_exp(d, 2'd0, ex);
        bus.in_valid = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            @(negedge clk);
            check("lat_early", bus.out_valid, 0);
        end
        @(negedge clk);
        check("lat_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;

        d = '0;
        d[55] = 1'b1;
        ex = '{lzc: {7'd0, 7'd0, 7'd56, 7'd0},
               z: 4'b0010, m: 2'd1};
        send_exp(d, 2'd1, ex);
        d = {28'h0, 28'h0000001, 28'h8000000, 28'h0100000};
        ex = '{lzc: {7'd28, 7'd27, 7'd0, 7'd7},
               z: 4'b1000, m: 2'd2};
        send_exp(d, 2'd2, ex);
        ex = '{lzc: {21'd0, 7'd112}, z: 4'b0001, m: 2'd0};
        send_exp('0, 2'd3, ex);
        bus.in_valid = 1'b0;
        drain();

        // Back-pressure: A holds while B, C queue behind it
        bus.out_ready = 1'b0;
        fork
            begin
                send(rand_data(), 2'($urandom_range(3)));
                send(rand_data(), 2'($urandom_range(3)));
                send(rand_data(), 2'($urandom_range(3)));
                bus.in_valid = 1'b0;
            end
            begin
                n = 0;
                @(negedge clk);
                while (!bus.out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_a_seen", bus.out_valid, 1);
                held_lzc = bus.out_lzc;
                held_z   = bus.out_zero;
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_lzc", bus.out_lzc, held_lzc);
                    check("hold_zero", bus.out_zero, held_z);
                end
                check("stall_in_ready", bus.in_ready, 0);
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight
        bus.out_ready = 1'b0;
        send(rand_data(), 2'd0);
        send(rand_data(), 2'd1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_in_ready",  bus.in_ready,  0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("stale_results", stale, 0);
        @(posedge clk);
        #1;

        rnd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(4) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
                rand_ready();
            end
            send(rand_data(), 2'($urandom_range(3)));
        end
        bus.in_valid  = 1'b0;
        rnd           = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lod_pipe.md
# lod_pipe

- Parametrised, pipelined, multi-precision leading-zero counter with a valid/ready handshake.
- Splits a WIDTH-bit normalisation operand into 1, 2, 4, … equal lanes, selected per transaction by `mode`.
- Returns each lane's leading-zero count and an all-zero flag.
- Sits between the FMA adder and the normaliser shifter, and replaces the fixed 106-bit DP/SP/HP detector.

## Interface
Parameters:
- `WIDTH`, default 112: operand width; must equal `LANES*SEG`.
- `LANES`, default 4: maximum lane count; power of two, at least 1.
- `SEG`, default 28: segment width; derived as `WIDTH/LANES`. Do not override.
- `POS_W`, default 7: count width; derived as `$clog2(WIDTH+1)`.
- `MODE_W`, default 2: mode width; derived as `$clog2($clog2(LANES)+1)`, minimum 1.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid && in_ready`.
- `in_data` in WIDTH: operand; bit WIDTH-1 is the MSB.
- `in_mode` in MODE_W: value m selects G=2^m lanes.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_lzc` out LANES*POS_W: lane g count in `[g*POS_W +: POS_W]`.
- `out_zero` out LANES: lane g all-zero flag.
- `out_mode` out MODE_W: mode of the result beat.

## Operation
- Lane g of G covers `in_data[(g+1)*WIDTH/G-1 : g*WIDTH/G]`.
- Count for lane g = number of zeros above its most significant one, measured from the lane MSB.
  - All-zero lane: count = WIDTH/G, zero flag = 1.
- Slots g ≥ G drive count 0 and zero flag 0.
- A mode value m > log2(LANES) is reserved and is processed as m=0 (full width); `out_mode` carries 0.
- Stage 1 (S1):
  - registers per-segment counts (LANES × `$clog2(SEG+1)` bits) and per-segment all-zero bits;
  - registers the effective mode.
- Stage 2 (S2), combining per group of LANES/G consecutive segments from the top segment downward:
  - add SEG for each all-zero segment;
  - at the first non-zero segment, add its count and stop.
- Arithmetic is unsigned, in POS_W bits; a count never exceeds WIDTH, so no overflow.
- Mode may change on every beat. Each beat carries its own mode through the pipe.

## Timing
- Reset value of every register and output is 0: `in_ready` is 0 during reset and 1 afterwards.
- Latency: 2 cycles from input accept to `out_valid` with no stalls. Throughput is one beat per cycle.
- Stall rule:
  - each stage register loads when it is empty or its consumer takes its contents in the same cycle;
  - `in_ready` = !S1.valid || S2 loads;
  - S2 loads when !S2.valid || `out_ready`.
- While `out_valid && !out_ready`, `out_lzc`, `out_zero` and `out_mode` hold stable.
- No combinational path from `in_valid` to `out_valid`.
- `out_ready` → `in_ready` is combinational, through at most two stage-empty terms.
- Simultaneous accept and drain on a full pipe: no bubble, no loss.
- Reset mid-operation clears all in-flight beats; no result is emitted for them.

## Configuration
- `LOD_PIPE_OUTREG_EN` defined: adds a third register stage (S3) on all outputs.
  - Latency becomes 3 cycles.
  - `in_ready` depends only on stage-valid flags and `out_ready`, through the same stall rule extended by one stage.
- `LOD_PIPE_OUTREG_EN` undefined: outputs are driven directly from S2, with latency 2.

## Structure
- Package `lod_pkg`:
  - mode constants `LOD_MODE_FULL=0`, `LOD_MODE_HALF=1`, `LOD_MODE_QUARTER=2`;
  - a typedef for the effective-mode field;
  - an elaboration check function asserting `WIDTH == LANES*SEG`.
- Sub-module `lod_seg`:
  - parameter `SEG`; combinational per-segment leading-zero count plus all-zero flag;
  - instantiated LANES times in front of S1.

## Test plan
1. WIDTH=112, mode 0, `in_data`=1<<100, `out_ready`=1 → after 2 cycles, lane 0 count 11, zero 0; slots 1–3 count 0, zero 0.
2. Mode 1, `in_data`[111:56]=0 and `in_data`[55]=1 → lane 1 count 56, zero 1; lane 0 count 0.
3. Mode 2, `in_data`=`{28'h0, 28'h0000001, 28'h8000000, 28'h0100000}` → counts lane3/2/1/0 = 28/27/0/7; zero flags = 4'b1000.
4. Back-to-back beats A, B, C with `out_ready` low for 3 cycles after A appears:
   - A holds stable and `in_ready` drops once S1 and S2 are full;
   - after release, A, B, C emerge in order with no loss.
5. Assert `rst` while two beats are in flight → `out_valid` 0 immediately; no stale result after release.
6. Reserved mode 3, with `in_data`=0 → count 112, lane 0 zero 1, `out_mode`=0.
